cache_data_bank: RTL and testbench

- Parametrised multi-way cache data array with byte-granular stores, single-cycle whole-line refill, and a parallel all-way read for tag-match selection.
- Includes a serialising write-back reader that snapshots one victim line and streams it word by word over a valid/ready handshake.
- Sits beside the tag/valid/dirty arrays inside the I/D cache, between the cache control FSM and the AXI bridge.

---
 rtl/cache_data_bank.sv | 133 +++++++++++++
 tb/tb_cache_data_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_bank.sv
// rtl/cache_data_bank.sv - multi-way cache data array with byte stores, line refill,
// all-way parallel read and a snapshotting write-back serialiser.
module cache_data_bank #(
  parameter int SETS  = 256,
  parameter int WAYS  = 2,
  parameter int WORDS = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_index,
  input  logic [OFF_W-1:0]      rd_offset,
  output logic [32*WAYS-1:0]    rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [WAY_W-1:0]      wr_way,
  input  logic [OFF_W-1:0]      wr_offset,
  input  logic [3:0]            wr_strb,
  input  logic [31:0]           wr_data,
  input  logic                  fill_en,
  input  logic [IDX_W-1:0]      fill_index,
  input  logic [WAY_W-1:0]      fill_way,
  input  logic [32*WORDS-1:0]   fill_line,
  input  logic                  wb_req,
  input  logic [IDX_W-1:0]      wb_index,
  input  logic [WAY_W-1:0]      wb_way,
  output logic                  wb_busy,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [31:0]           wb_data,
  output logic                  wb_last
);

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } wb_state_t;

  logic [31:0]      r_mem [WAYS][SETS][WORDS];
  logic [31:0]      r_buf [WORDS];
  wb_state_t        r_state;
  wb_state_t        w_next_state;
  logic [IDX_W-1:0] r_wb_index;
  logic [WAY_W-1:0] r_wb_way;
  logic [OFF_W-1:0] r_cnt;
  logic             w_store_blocked;
  logic             w_accept;
  logic             w_handshake;

  // A refill of the same line supersedes a concurrent store to it.
  assign w_store_blocked = fill_en && (fill_index == wr_index) && (fill_way == wr_way);

  always_ff @(posedge clk) begin
    if (wr_en && !w_store_blocked) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          r_mem[wr_way][wr_index][wr_offset][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (fill_en) begin
      for (int k = 0; k < WORDS; k++) begin
        r_mem[fill_way][fill_index][k] <= fill_line[32*k +: 32];
      end
    end
  end

  // Non-blocking reads give read-first behaviour against same-edge writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_data[32*w +: 32] <= r_mem[w][rd_index][rd_offset];
      end
    end
  end

  assign w_accept    = (r_state == ST_IDLE) && wb_req;
  assign w_handshake = (r_state == ST_SEND) && wb_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (wb_req) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_SEND;
      ST_SEND: if (wb_ready && (r_cnt == LAST_WORD)) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_LOAD) begin
        r_cnt <= '0;
      end else if (w_handshake) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wb_index <= wb_index;
      r_wb_way   <= wb_way;
    end
  end

  // Snapshot taken at the LOAD edge: sees accept-cycle writes, not LOAD-cycle writes.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      for (int k = 0; k < WORDS; k++) begin
        r_buf[k] <= r_mem[r_wb_way][r_wb_index][k];
      end
    end
  end

  assign wb_busy  = (r_state != ST_IDLE);
  assign wb_valid = (r_state == ST_SEND);
  assign wb_last  = wb_valid && (r_cnt == LAST_WORD);
  assign wb_data  = wb_valid ? r_buf[r_cnt] : 32'h0;

endmodule

// File: tb/tb_cache_data_bank.sv
// tb/tb_cache_data_bank.sv - scoreboard bench for cache_data_bank against an array model.
module tb_cache_data_bank;

  localparam int SETS = 256, WAYS = 2, WORDS = 4;
  localparam int IDX_W = 8, WAY_W = 1, OFF_W = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                rd_en = 1'b0;
  logic [IDX_W-1:0]    rd_index = '0;
  logic [OFF_W-1:0]    rd_offset = '0;
  logic [32*WAYS-1:0]  rd_data;
  logic                wr_en = 1'b0;
  logic [IDX_W-1:0]    wr_index = '0;
  logic [WAY_W-1:0]    wr_way = '0;
  logic [OFF_W-1:0]    wr_offset = '0;
  logic [3:0]          wr_strb = '0;
  logic [31:0]         wr_data = '0;
  logic                fill_en = 1'b0;
  logic [IDX_W-1:0]    fill_index = '0;
  logic [WAY_W-1:0]    fill_way = '0;
  logic [32*WORDS-1:0] fill_line = '0;
  logic                wb_req = 1'b0;
  logic [IDX_W-1:0]    wb_index = '0;
  logic [WAY_W-1:0]    wb_way = '0;
  logic                wb_busy;
  logic                wb_valid;
  logic                wb_ready = 1'b1;
  logic [31:0]         wb_data;
  logic                wb_last;

  cache_data_bank #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_index(rd_index), .rd_offset(rd_offset), .rd_data(rd_data),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_offset(wr_offset),
    .wr_strb(wr_strb), .wr_data(wr_data),
    .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way), .fill_line(fill_line),
    .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way), .wb_busy(wb_busy),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0]         m [WAYS][SETS][WORDS];
  logic [32*WAYS-1:0]  rd_q [$];
  logic [32:0]         wb_q [$];
  logic [32*WAYS-1:0]  exp_last = '0;
  bit                  active = 0;
  bit                  loading = 0;
  int                  remaining = 0;
  bit                  mon_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour evaluated at each rising edge with the inputs as sampled.
  task automatic model_edge();
    bit acc;
    logic [32*WAYS-1:0] v;
    acc = 0;
    if (reset) begin
      active = 0; loading = 0; remaining = 0;
      wb_q.delete(); rd_q.delete(); exp_last = '0;
    end else begin
      if (rd_en) begin
        v = '0;
        for (int w = 0; w < WAYS; w++) v[32*w +: 32] = m[w][rd_index][rd_offset];
        rd_q.push_back(v);
      end
      acc = !active && wb_req;
      if (active) begin
        if (loading) loading = 0;
        else if (wb_ready) begin
          remaining--;
          if (remaining == 0) active = 0;
        end
      end
    end
    if (wr_en && !(fill_en && fill_index == wr_index && fill_way == wr_way)) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) m[wr_way][wr_index][wr_offset][8*b +: 8] = wr_data[8*b +: 8];
    end
    if (fill_en) begin
      for (int k = 0; k < WORDS; k++) m[fill_way][fill_index][k] = fill_line[32*k +: 32];
    end
    if (acc) begin
      active = 1; loading = 1; remaining = WORDS;
      for (int k = 0; k < WORDS; k++) wb_q.push_back({(k == WORDS - 1), m[wb_way][wb_index][k]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    rd_en = 0; wr_en = 0; fill_en = 0; wb_req = 0; wr_strb = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_q.size() > 0) exp_last = rd_q.pop_front();
      chk("rd_data", rd_data, exp_last);
      chk("wb_busy", wb_busy, active);
      chk("wb_valid", wb_valid, active && !loading);
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected_word", 1'b1, 1'b0);
        end else begin
          chk("wb_data", wb_data, wb_q[0][31:0]);
          chk("wb_last", wb_last, wb_q[0][32]);
          if (wb_ready) void'(wb_q.pop_front());
        end
      end
    end
  end

  logic [32*WORDS-1:0] line_a;
  logic [31:0] hold_d;
  logic        hold_l;

  initial begin
    step(); step();
    reset = 0;
    mon_en = 1;
    chk("reset_rd_data", rd_data, '0);
    chk("reset_wb_busy", wb_busy, 1'b0);

    for (int w = 0; w < WAYS; w++) begin
      for (int s = 0; s < SETS; s++) begin
        fill_en = 1; fill_way = WAY_W'(w); fill_index = IDX_W'(s);
        for (int k = 0; k < WORDS; k++) fill_line[32*k +: 32] = $urandom;
        step();
      end
    end

    fill_en = 1; fill_index = 5; fill_way = 1;
    fill_line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    step();
    rd_en = 1; rd_index = 5; rd_offset = 2;
    step();
    chk("fill_read_word2", rd_data[63:32], 32'h33333333);

    wr_en = 1; wr_index = 5; wr_way = 1; wr_offset = 0; wr_strb = 4'b0101; wr_data = 32'hAABBCCDD;
    rd_en = 1; rd_index = 5; rd_offset = 0;
    step();
    chk("same_cycle_read_old", rd_data[63:32], 32'h11111111);
    rd_en = 1;
    step();
    chk("next_cycle_read_new", rd_data[63:32], 32'h11BB11DD);
    step();
    chk("rd_data_hold", rd_data[63:32], 32'h11BB11DD);

    line_a = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
    fill_en = 1; fill_index = 5; fill_way = 1; fill_line = line_a;
    wr_en = 1; wr_index = 5; wr_way = 1; wr_offset = 1; wr_strb = 4'hF; wr_data = 32'hDEADBEEF;
    step();
    rd_en = 1; rd_index = 5; rd_offset = 1;
    step();
    chk("fill_beats_store", rd_data[63:32], 32'h66666666);

    wb_ready = 1; wb_req = 1; wb_index = 5; wb_way = 1;
    step();
    chk("wb_busy_after_req", wb_busy, 1'b1);
    chk("wb_valid_in_load", wb_valid, 1'b0);
    step();
    for (int k = 0; k < WORDS; k++) begin
      chk("wb_stream_valid", wb_valid, 1'b1);
      chk("wb_stream_data", wb_data, line_a[32*k +: 32]);
      chk("wb_stream_last", wb_last, (k == WORDS - 1));
      step();
    end
    chk("wb_idle_after_stream", wb_busy, 1'b0);

    wb_req = 1; wb_index = 5; wb_way = 1;
    step(); step(); step();
    wb_ready = 0;
    hold_d = wb_data; hold_l = wb_last;
    chk("bp_word1", hold_d, 32'h66666666);
    wr_en = 1; wr_index = 5; wr_way = 1; wr_offset = 2; wr_strb = 4'hF; wr_data = 32'h0BADF00D;
    wb_req = 1; wb_index = 7; wb_way = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", wb_data, hold_d);
      chk("bp_hold_last", wb_last, hold_l);
    end
    wb_ready = 1;
    step();
    chk("bp_snapshot_word2", wb_data, 32'h77777777);
    step(); step();
    chk("bp_busy_req_ignored", wb_busy, 1'b0);
    step();

    wb_req = 1; wb_index = 5; wb_way = 1;
    step(); step(); step();
    reset = 1;
    step();
    reset = 0;
    chk("rst_mid_valid", wb_valid, 1'b0);
    chk("rst_mid_busy", wb_busy, 1'b0);
    wb_req = 1; wb_index = 5; wb_way = 1;
    step(); step();
    chk("restart_word0", wb_data, 32'h55555555);
    chk("restart_last", wb_last, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      wb_ready   = ($urandom_range(0, 9) < 7);
      reset      = ($urandom_range(0, 199) == 0);
      rd_en      = $urandom_range(0, 1);
      rd_index   = IDX_W'($urandom_range(5, 8));
      rd_offset  = OFF_W'($urandom);
      wr_en      = ($urandom_range(0, 9) < 4);
      wr_index   = IDX_W'($urandom_range(5, 8));
      wr_way     = WAY_W'($urandom);
      wr_offset  = OFF_W'($urandom);
      wr_strb    = 4'($urandom);
      wr_data    = $urandom;
      fill_en    = ($urandom_range(0, 9) < 2);
      fill_index = IDX_W'($urandom_range(5, 8));
      fill_way   = WAY_W'($urandom);
      for (int k = 0; k < WORDS; k++) fill_line[32*k +: 32] = $urandom;
      wb_req     = ($urandom_range(0, 4) == 0);
      wb_index   = IDX_W'($urandom_range(5, 8));
      wb_way     = WAY_W'($urandom);
      step();
    end
    reset = 0; wb_ready = 1;
    for (int i = 0; i < 12; i++) step();
    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
